xbit_serializer: RTL and testbench
==================================

Name: xbit_serializer

Overview:
- Transmit-side parallel-to-serial shifter. Accepts DW*RATIO-bit words on a valid/ready handshake and emits them as RATIO consecutive DW-bit beats on a valid/ready lane.
- Provides first-beat and last-beat markers.
- Sits at the transmit end of serial lanes. The matching receive path uses DW-wide delay/shift chains to rebuild words.
- A one-word holding buffer lets back-to-back words stream without a bubble.

Parameters:
- DW, 1, lane (beat) width in bits, >=1.
- RATIO, 4, beats per word, >=2.
- MSB_FIRST, 0: 0 sends bits [DW-1:0] first; 1 sends the top DW bits first.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_data  input  DW*RATIO  parallel word.
- i_valid  input  1  i_data valid.
- o_ready  output  1  block can accept a word this cycle.
- o_data  output  DW  current lane beat.
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts the beat this cycle.
- o_sof  output  1  current beat is beat 0 of a word; qualified by o_valid.
- o_eof  output  1  current beat is beat RATIO-1; qualified by o_valid.

Behaviour:
- Reset and clocking
  - Reset is asynchronous assert, synchronous release on i_clk.
  - On reset, clear the shift register, beat counter, buffer, buf_full and active: o_valid=0, o_data=0, o_sof=0, o_eof=0.
- Handshakes
  - o_ready = !buf_full, combinational from a flop. It reads 1 out of reset.
  - Word accept = i_valid && o_ready.
  - Beat transfer = o_valid && i_ready.
  - o_data, o_sof and o_eof are held stable while o_valid=1 and i_ready=0.
- State machine
  - IDLE (active=0): o_valid=0.
    - On accept, load i_data into the shifter, count=0, go to SHIFT.
    - First beat appears on o_valid at the next cycle (latency 1).
  - SHIFT (active=1): o_valid=1.
    - On a transfer with count<RATIO-1: shift by DW (toward the LSB when MSB_FIRST=0, toward the MSB when MSB_FIRST=1) and count++.
    - On a transfer with count==RATIO-1 (last beat):
      - If buf_full: load buffer into the shifter, clear buf_full, count=0, stay in SHIFT.
      - Else if accept this cycle: load i_data directly, count=0, stay in SHIFT.
      - Else go to IDLE.
  - An accept in SHIFT that is not consumed by the last-beat rule writes the buffer and sets buf_full=1.
- Outputs
  - o_data is the low DW bits of the shifter (MSB_FIRST=0) or the high DW bits (MSB_FIRST=1).
  - o_sof = active && count==0.
  - o_eof = active && count==RATIO-1.
- Counter width: $clog2(RATIO); it never exceeds RATIO-1.
- Throughput: with i_valid=1 and i_ready=1 continuously, o_valid stays 1 with no bubble between words (one word per RATIO cycles).
- Boundary conditions
  - The buffer holds at most one word, so at most two words are in flight.
  - A last-beat transfer with buf_full=1 and i_valid=1 in the same cycle: the buffer moves to the shifter, and o_ready was 0, so i_data is not taken. o_ready rises on the following cycle.
  - i_valid with o_ready=0 is ignored; the upstream must hold the word.
  - i_ready=0 forever: the block holds the current beat, accepts one word into the buffer, then deasserts o_ready.
  - Reset mid-word: the word in flight and the buffered word are discarded. Outputs clear immediately.
  - X on i_data with i_valid=0 never propagates to o_data.

Test Plan:
- DW=4, RATIO=4, MSB_FIRST=0; send 0x1234 with i_ready=1 -> o_data = 4,3,2,1 on consecutive cycles starting 1 cycle after accept; o_sof on beat 4, o_eof on beat 1; then o_valid=0.
- Same word with MSB_FIRST=1 -> beats 1,2,3,4; sof/eof on 1/4.
- Back-to-back 0x1234, 0xABCD, 0x5678 with i_valid=1 and i_ready=1 -> 12 contiguous valid beats 4,3,2,1,D,C,B,A,8,7,6,5; o_ready drops only while buf_full.
- Backpressure: i_ready=0 for 10 cycles mid-word (after beat 3) -> o_data stays 3; a second word is buffered and o_ready=0; on release the remaining beats 2,1 continue, then the buffered word follows with no gap.
- Assert i_rst_n=0 during beat 2 with a word buffered -> o_valid, o_sof, o_eof and o_data go to 0 asynchronously; after release o_ready=1, and a new word 0x00F0 streams 0,F,0,0.
- DW=1, RATIO=8, MSB_FIRST=0, word 0xA5 -> serial bits 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/xbit_serializer.sv
// Parallel-to-serial lane shifter: DW*RATIO-bit words out as RATIO DW-bit beats.
// A one-word holding buffer lets back-to-back words stream without a bubble.
module xbit_serializer #(
    parameter int DW        = 1,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DW*RATIO-1:0] i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [DW-1:0]       o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_sof,
    output logic                o_eof
);

    localparam int W  = DW * RATIO;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          buf_full_q, buf_full_d;
    logic          accept;
    logic          xfer;
    logic          last;

    assign o_ready = !buf_full_q;
    assign accept  = i_valid && !buf_full_q;
    assign xfer    = (state_q == SHIFT) && i_ready;
    assign last    = (cnt_q == CW'(RATIO - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            buf_full_q <= buf_full_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        buf_full_d = buf_full_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = i_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A word arriving on the last-beat transfer goes straight to the shifter.
                if (accept && !(xfer && last)) begin
                    buf_d      = i_data;
                    buf_full_d = 1'b1;
                end
                if (xfer) begin
                    if (!last) begin
                        shift_d = MSB_FIRST ? (shift_q << DW) : (shift_q >> DW);
                        cnt_d   = cnt_q + CW'(1);
                    end else if (buf_full_q) begin
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
                        cnt_d      = '0;
                    end else if (accept) begin
                        shift_d = i_data;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_valid = (state_q == SHIFT);
    assign o_data  = MSB_FIRST ? shift_q[W-1 -: DW] : shift_q[DW-1:0];
    assign o_sof   = o_valid && (cnt_q == '0);
    assign o_eof   = o_valid && last;

endmodule

// File: tb/tb_xbit_serializer.sv
// Directed bench for xbit_serializer: LSB-first, MSB-first and 1-bit lanes.
// Table-driven streaming plus hand-written backpressure, reset and serial cases.
module tb_xbit_serializer;

    logic        clk;
    logic        rst_n;
    logic [15:0] d;
    logic        v;
    logic        r;
    logic        o0_rdy, o0_v, o0_sof, o0_eof;
    logic [3:0]  o0_d;
    logic        o1_rdy, o1_v, o1_sof, o1_eof;
    logic [3:0]  o1_d;
    logic [7:0]  d2;
    logic        v2, r2;
    logic        o2_rdy, o2_v, o2_sof, o2_eof;
    logic [0:0]  o2_d;

    int n_tests = 0;
    int n_fail  = 0;

    xbit_serializer #(.DW(4), .RATIO(4), .MSB_FIRST(1'b0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d), .i_valid(v),
        .o_ready(o0_rdy), .o_data(o0_d), .o_valid(o0_v), .i_ready(r),
        .o_sof(o0_sof), .o_eof(o0_eof)
    );

    xbit_serializer #(.DW(4), .RATIO(4), .MSB_FIRST(1'b1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d), .i_valid(v),
        .o_ready(o1_rdy), .o_data(o1_d), .o_valid(o1_v), .i_ready(r),
        .o_sof(o1_sof), .o_eof(o1_eof)
    );

    xbit_serializer #(.DW(1), .RATIO(8), .MSB_FIRST(1'b0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d2), .i_valid(v2),
        .o_ready(o2_rdy), .o_data(o2_d), .o_valid(o2_v), .i_ready(r2),
        .o_sof(o2_sof), .o_eof(o2_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        r;
        logic        ev;
        logic [3:0]  ed0;
        logic [3:0]  ed1;
        logic        es;
        logic        ee;
        logic        erdy;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic vi, logic [15:0] di, logic ri, logic ev,
                                logic [3:0] e0, logic [3:0] e1, logic es,
                                logic ee, logic erdy);
        vec_t t;
        t.v = vi; t.d = di; t.r = ri; t.ev = ev; t.ed0 = e0; t.ed1 = e1;
        t.es = es; t.ee = ee; t.erdy = erdy;
        return t;
    endfunction

    logic [3:0] bp0[7];
    logic [3:0] bp1[7];
    logic       bprdy[7];
    logic [3:0] rs0[4];
    logic [3:0] rs1[4];
    logic [7:0] ser;

    initial begin
        tbl[0]  = mk(1, 16'h1234, 1, 0, 4'h0, 4'h0, 0, 0, 1);
        tbl[1]  = mk(1, 16'hABCD, 1, 1, 4'h4, 4'h1, 1, 0, 1);
        tbl[2]  = mk(1, 16'h5678, 1, 1, 4'h3, 4'h2, 0, 0, 0);
        tbl[3]  = mk(1, 16'h5678, 1, 1, 4'h2, 4'h3, 0, 0, 0);
        tbl[4]  = mk(1, 16'h5678, 1, 1, 4'h1, 4'h4, 0, 1, 0);
        tbl[5]  = mk(1, 16'h5678, 1, 1, 4'hD, 4'hA, 1, 0, 1);
        tbl[6]  = mk(0, 16'h0000, 1, 1, 4'hC, 4'hB, 0, 0, 0);
        tbl[7]  = mk(0, 16'h0000, 1, 1, 4'hB, 4'hC, 0, 0, 0);
        tbl[8]  = mk(0, 16'h0000, 1, 1, 4'hA, 4'hD, 0, 1, 0);
        tbl[9]  = mk(0, 16'h0000, 1, 1, 4'h8, 4'h5, 1, 0, 1);
        tbl[10] = mk(0, 16'h0000, 1, 1, 4'h7, 4'h6, 0, 0, 1);
        tbl[11] = mk(0, 16'h0000, 1, 1, 4'h6, 4'h7, 0, 0, 1);
        tbl[12] = mk(0, 16'h0000, 1, 1, 4'h5, 4'h8, 0, 1, 1);
        tbl[13] = mk(0, 16'h0000, 1, 0, 4'h0, 4'h0, 0, 0, 1);
        bp0 = '{4'h3, 4'h2, 4'h1, 4'hD, 4'hC, 4'hB, 4'hA};
        bp1 = '{4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
        bprdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rs0 = '{4'h0, 4'hF, 4'h0, 4'h0};
        rs1 = '{4'h0, 4'h0, 4'hF, 4'h0};
        ser = 8'hA5;

        rst_n = 1'b0; v = 1'b0; d = 16'hxxxx; r = 1'b1;
        v2 = 1'b0; d2 = 8'hxx; r2 = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_u0_valid", o0_v, 0);
        chk("rst_u0_data", o0_d, 0);
        chk("rst_u0_sof", o0_sof, 0);
        chk("rst_u0_eof", o0_eof, 0);
        chk("rst_u0_ready", o0_rdy, 1);
        chk("rst_u1_valid", o1_v, 0);
        chk("rst_u1_data", o1_d, 0);
        chk("rst_u2_valid", o2_v, 0);
        chk("rst_u2_ready", o2_rdy, 1);
        tick();
        chk("xdata_u0_valid", o0_v, 0);

        // Back-to-back streaming table
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("tbl%0d_u0_valid", i), o0_v, tbl[i].ev);
            chk($sformatf("tbl%0d_u1_valid", i), o1_v, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_u0_data", i), o0_d, tbl[i].ed0);
                chk($sformatf("tbl%0d_u1_data", i), o1_d, tbl[i].ed1);
            end
            chk($sformatf("tbl%0d_u0_sof", i), o0_sof, tbl[i].es);
            chk($sformatf("tbl%0d_u0_eof", i), o0_eof, tbl[i].ee);
            chk($sformatf("tbl%0d_u1_sof", i), o1_sof, tbl[i].es);
            chk($sformatf("tbl%0d_u1_eof", i), o1_eof, tbl[i].ee);
            chk($sformatf("tbl%0d_u0_ready", i), o0_rdy, tbl[i].erdy);
            v = tbl[i].v; d = tbl[i].d; r = tbl[i].r;
            tick();
        end

        // Backpressure: stall 10 cycles on beat 3 with a word buffered
        v = 1'b1; d = 16'h1234; r = 1'b1;
        tick();
        v = 1'b0; d = 16'hxxxx;
        chk("bp_beat0_u0", o0_d, 4'h4);
        tick();
        chk("bp_beat1_u0", o0_d, 4'h3);
        chk("bp_beat1_u1", o1_d, 4'h2);
        r = 1'b0; v = 1'b1; d = 16'hABCD;
        tick();
        v = 1'b0; d = 16'hxxxx;
        for (int i = 0; i < 9; i++) begin
            chk("bp_stall_valid", o0_v, 1);
            chk("bp_stall_u0", o0_d, 4'h3);
            chk("bp_stall_u1", o1_d, 4'h2);
            chk("bp_stall_sof", o0_sof, 0);
            chk("bp_stall_ready", o0_rdy, 0);
            tick();
        end
        r = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("bp_rel%0d_valid", i), o0_v, 1);
            chk($sformatf("bp_rel%0d_u0", i), o0_d, bp0[i]);
            chk($sformatf("bp_rel%0d_u1", i), o1_d, bp1[i]);
            chk($sformatf("bp_rel%0d_ready", i), o0_rdy, bprdy[i]);
            chk($sformatf("bp_rel%0d_sof", i), o0_sof, (i == 3));
            tick();
        end
        chk("bp_done_valid", o0_v, 0);

        // Reset during beat 2 with a word buffered
        v = 1'b1; d = 16'h1234;
        tick();
        d = 16'hABCD;
        tick();
        v = 1'b0; d = 16'hxxxx;
        chk("rm_pre_data", o0_d, 4'h3);
        chk("rm_pre_ready", o0_rdy, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_u0_valid", o0_v, 0);
        chk("rm_u0_data", o0_d, 0);
        chk("rm_u0_sof", o0_sof, 0);
        chk("rm_u0_eof", o0_eof, 0);
        chk("rm_u1_valid", o1_v, 0);
        chk("rm_u1_data", o1_d, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("rm_post_ready", o0_rdy, 1);
        chk("rm_post_valid", o0_v, 0);
        v = 1'b1; d = 16'h00F0;
        tick();
        v = 1'b0; d = 16'hxxxx;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rm_new%0d_valid", i), o0_v, 1);
            chk($sformatf("rm_new%0d_u0", i), o0_d, rs0[i]);
            chk($sformatf("rm_new%0d_u1", i), o1_d, rs1[i]);
            chk($sformatf("rm_new%0d_eof", i), o0_eof, (i == 3));
            tick();
        end
        chk("rm_new_done", o0_v, 0);

        // 1-bit lane, 8 beats
        v2 = 1'b1; d2 = 8'hA5;
        tick();
        v2 = 1'b0; d2 = 8'hxx;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ser%0d_valid", i), o2_v, 1);
            chk($sformatf("ser%0d_bit", i), o2_d, ser[i]);
            chk($sformatf("ser%0d_sof", i), o2_sof, (i == 0));
            chk($sformatf("ser%0d_eof", i), o2_eof, (i == 7));
            tick();
        end
        chk("ser_done_valid", o2_v, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
